// File: rtl/intr_pkg.sv
// Shared constants and types for the machine-mode interrupt controller.
package intr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MCAUSE_EXT_BASE  = 16;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    HANDLER = 1'b1
  } state_e;

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-wins priority encoder over the active interrupt set.
module intr_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic [3:0]   id,
  output logic         any
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    id  = '0;
    any = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) id = 4'(i);
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Machine-mode interrupt controller: edge capture, masking, trap CSRs and
// the one-cycle PC redirect for trap entry and MRET.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int              NUM_IRQ     = 8,
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100,
  parameter bit              VECTORED    = 1'b1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_IRQ-1:0] irq,
  output logic               interrupt_req,
  input  logic               interrupt_taken,
  input  logic               mret_taken,
  input  logic [XLEN-1:0]    pc_resume,
  input  logic               csr_we,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_q, pending_q, pending_d, mie_q, mie_d;
  logic               mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic [XLEN-1:0]    mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic               redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]    redirect_pc_q, redirect_pc_d;

  logic [NUM_IRQ-1:0] rise, active, claim_mask, w1c_mask;
  logic [3:0]         id;
  logic               any_active, take;
  logic               wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause, wr_mip;
  logic [XLEN-1:0]    trap_pc;

  intr_prio_enc #(.N(NUM_IRQ)) u_prio (
    .req (active),
    .id  (id),
    .any (any_active)
  );

  assign rise          = irq & ~irq_q;
  assign active        = pending_q & mie_q;
  assign interrupt_req = (state_q == IDLE) & mst_mie_q & any_active;
  assign take          = interrupt_req & interrupt_taken;

  assign wr_mstatus = csr_we & (csr_addr == CSR_MSTATUS);
  assign wr_mie     = csr_we & (csr_addr == CSR_MIE);
  assign wr_mtvec   = csr_we & (csr_addr == CSR_MTVEC);
  assign wr_mepc    = csr_we & (csr_addr == CSR_MEPC);
  assign wr_mcause  = csr_we & (csr_addr == CSR_MCAUSE);
  assign wr_mip     = csr_we & (csr_addr == CSR_MIP);

  assign claim_mask = take ? (NUM_IRQ'(1) << id) : '0;
  assign w1c_mask   = wr_mip ? csr_wdata[NUM_IRQ-1:0] : '0;
  assign trap_pc    = VECTORED ? (mtvec_q + (XLEN'(id) << 2)) : mtvec_q;

  always_comb begin
    state_d          = state_q;
    // A fresh edge is OR-ed in last so it survives a same-cycle claim or clear.
    pending_d        = (pending_q & ~(claim_mask | w1c_mask)) | rise;
    mie_d            = wr_mie ? csr_wdata[NUM_IRQ-1:0] : mie_q;
    mtvec_d          = wr_mtvec ? (csr_wdata & ALIGN_MASK) : mtvec_q;
    mst_mie_d        = mst_mie_q;
    mst_mpie_d       = mst_mpie_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    if (take) begin
      state_d          = HANDLER;
      mepc_d           = pc_resume & ALIGN_MASK;
      mcause_d         = {1'b1, (XLEN-1)'(MCAUSE_EXT_BASE) + (XLEN-1)'(id)};
      mst_mpie_d       = mst_mie_q;
      mst_mie_d        = 1'b0;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = trap_pc;
    end else if (mret_taken) begin
      state_d          = IDLE;
      mst_mie_d        = mst_mpie_q;
      mst_mpie_d       = 1'b1;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = mepc_q;
    end else begin
      if (wr_mstatus) begin
        mst_mie_d  = csr_wdata[MSTATUS_MIE_BIT];
        mst_mpie_d = csr_wdata[MSTATUS_MPIE_BIT];
      end
      if (wr_mepc)   mepc_d   = csr_wdata & ALIGN_MASK;
      if (wr_mcause) mcause_d = csr_wdata;
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE_BIT]  = mst_mie_q;
        csr_rdata[MSTATUS_MPIE_BIT] = mst_mpie_q;
      end
      CSR_MIE:    csr_rdata = XLEN'(mie_q);
      CSR_MTVEC:  csr_rdata = mtvec_q;
      CSR_MEPC:   csr_rdata = mepc_q;
      CSR_MCAUSE: csr_rdata = mcause_q;
      CSR_MIP:    csr_rdata = XLEN'(pending_q);
      default:    csr_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q          <= IDLE;
      irq_q            <= '0;
      pending_q        <= '0;
      mie_q            <= '0;
      mst_mie_q        <= 1'b0;
      mst_mpie_q       <= 1'b0;
      mtvec_q          <= MTVEC_RESET;
      mepc_q           <= '0;
      mcause_q         <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      irq_q            <= irq;
      pending_q        <= pending_d;
      mie_q            <= mie_d;
      mst_mie_q        <= mst_mie_d;
      mst_mpie_q       <= mst_mpie_d;
      mtvec_q          <= mtvec_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl with hand-computed expectations.
module tb_intr_ctrl;
  import intr_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  irq;
  logic        interrupt_req;
  logic        interrupt_taken;
  logic        mret_taken;
  logic [31:0] pc_resume;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_tests = 0;
  int n_fail  = 0;

  intr_ctrl dut (
    .clk             (clk),
    .rstn            (rstn),
    .irq             (irq),
    .interrupt_req   (interrupt_req),
    .interrupt_taken (interrupt_taken),
    .mret_taken      (mret_taken),
    .pc_resume       (pc_resume),
    .csr_we          (csr_we),
    .csr_addr        (csr_addr),
    .csr_wdata       (csr_wdata),
    .csr_rdata       (csr_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_we    = 1'b1;
    csr_addr  = addr;
    csr_wdata = data;
    tick();
    csr_we    = 1'b0;
    $display("[TB] csr write addr=0x%03h data=0x%08h", addr, data);
  endtask

  task automatic csr_check(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr = addr;
    #1;
    check(tag, csr_rdata, exp);
  endtask

  initial begin
    rstn = 1'b0; irq = '0; interrupt_taken = 1'b0; mret_taken = 1'b0;
    pc_resume = '0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
    tick(); tick();
    rstn = 1'b1;
    tick();
    $display("[TB] reset released");
    check("rst_req", 32'(interrupt_req), 32'd0);
    check("rst_rv", 32'(redirect_valid), 32'd0);
    check("rst_rpc", redirect_pc, 32'h0);
    csr_check("rst_mtvec", CSR_MTVEC, 32'h100);
    csr_check("rst_mstatus", CSR_MSTATUS, 32'h0);

    // Single interrupt on line 0, full trap entry
    csr_write(CSR_MIE, 32'h01);
    csr_write(CSR_MSTATUS, 32'h08);
    csr_check("mstatus_wr", CSR_MSTATUS, 32'h08);
    irq = 8'h01;
    #1;
    check("req_before_edge", 32'(interrupt_req), 32'd0);
    tick();
    irq = 8'h00;
    check("req_after_edge", 32'(interrupt_req), 32'd1);
    interrupt_taken = 1'b1; pc_resume = 32'h200;
    tick();
    interrupt_taken = 1'b0;
    $display("[TB] take irq0 pc_resume=0x200");
    check("t1_rv", 32'(redirect_valid), 32'd1);
    check("t1_rpc", redirect_pc, 32'h100);
    check("t1_req", 32'(interrupt_req), 32'd0);
    csr_check("t1_mepc", CSR_MEPC, 32'h200);
    csr_check("t1_mcause", CSR_MCAUSE, 32'h8000_0010);
    csr_check("t1_mstatus", CSR_MSTATUS, 32'h80);
    tick();
    check("t1_rv_drop", 32'(redirect_valid), 32'd0);

    // MRET back to the interrupted PC
    mret_taken = 1'b1;
    tick();
    mret_taken = 1'b0;
    $display("[TB] mret");
    check("m1_rv", 32'(redirect_valid), 32'd1);
    check("m1_rpc", redirect_pc, 32'h200);
    csr_check("m1_mstatus", CSR_MSTATUS, 32'h88);
    tick();
    check("m1_rv_drop", 32'(redirect_valid), 32'd0);

    // Two simultaneous edges: lowest index wins
    csr_write(CSR_MIE, 32'hFF);
    irq = 8'h24;
    tick();
    irq = 8'h00;
    check("t2_req", 32'(interrupt_req), 32'd1);
    csr_check("t2_mip_pre", CSR_MIP, 32'h24);
    interrupt_taken = 1'b1; pc_resume = 32'h300;
    tick();
    interrupt_taken = 1'b0;
    $display("[TB] take irq2 pc_resume=0x300");
    check("t2_rpc", redirect_pc, 32'h108);
    csr_check("t2_mcause", CSR_MCAUSE, 32'h8000_0012);
    csr_check("t2_mip", CSR_MIP, 32'h20);
    check("t2_hnd_req", 32'(interrupt_req), 32'd0);

    // No nesting while in the handler
    irq = 8'h02;
    tick();
    irq = 8'h00;
    check("nest_req0", 32'(interrupt_req), 32'd0);
    tick();
    check("nest_req1", 32'(interrupt_req), 32'd0);
    csr_check("nest_mip", CSR_MIP, 32'h22);
    mret_taken = 1'b1;
    tick();
    mret_taken = 1'b0;
    $display("[TB] mret from irq2 handler");
    check("m2_rpc", redirect_pc, 32'h300);
    check("m2_req", 32'(interrupt_req), 32'd1);
    interrupt_taken = 1'b1; pc_resume = 32'h400;
    tick();
    interrupt_taken = 1'b0;
    $display("[TB] take irq1 pc_resume=0x400");
    check("t3_rpc", redirect_pc, 32'h104);
    csr_check("t3_mcause", CSR_MCAUSE, 32'h8000_0011);
    mret_taken = 1'b1;
    tick();
    mret_taken = 1'b0;
    check("m3_rpc", redirect_pc, 32'h400);

    // W1C on mip, and set-wins against a same-cycle edge
    csr_write(CSR_MSTATUS, 32'h0);
    check("mie_off_req", 32'(interrupt_req), 32'd0);
    csr_write(CSR_MIP, 32'hFF);
    csr_check("mip_clear", CSR_MIP, 32'h0);
    irq = 8'h0C;
    tick();
    irq = 8'h00;
    csr_check("mip_0c", CSR_MIP, 32'h0C);
    csr_write(CSR_MIP, 32'h04);
    csr_check("mip_w1c", CSR_MIP, 32'h08);
    irq = 8'h04;
    csr_write(CSR_MIP, 32'h0C);
    irq = 8'h00;
    csr_check("mip_setwins", CSR_MIP, 32'h04);

    // MIE write raises the request on the next cycle
    csr_write(CSR_MSTATUS, 32'h08);
    check("mie_on_req", 32'(interrupt_req), 32'd1);

    // mtvec/mepc alignment, unmapped address, trap beats a mepc write
    csr_write(CSR_MTVEC, 32'h203);
    csr_check("mtvec_align", CSR_MTVEC, 32'h200);
    csr_write(12'h7C0, 32'hDEAD_BEEF);
    csr_check("unmapped", 12'h7C0, 32'h0);
    interrupt_taken = 1'b1; pc_resume = 32'h503;
    csr_we = 1'b1; csr_addr = CSR_MEPC; csr_wdata = 32'h999;
    tick();
    interrupt_taken = 1'b0; csr_we = 1'b0;
    $display("[TB] take irq2 with concurrent mepc write");
    check("t4_rpc", redirect_pc, 32'h208);
    csr_check("t4_mepc", CSR_MEPC, 32'h500);

    // Reset while in the handler
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    $display("[TB] reset in handler");
    check("r2_req", 32'(interrupt_req), 32'd0);
    check("r2_rv", 32'(redirect_valid), 32'd0);
    check("r2_rpc", redirect_pc, 32'h0);
    csr_check("r2_mtvec", CSR_MTVEC, 32'h100);
    csr_check("r2_mstatus", CSR_MSTATUS, 32'h0);
    csr_check("r2_mepc", CSR_MEPC, 32'h0);
    csr_check("r2_mcause", CSR_MCAUSE, 32'h0);
    csr_check("r2_mip", CSR_MIP, 32'h0);
    csr_check("r2_mie", CSR_MIE, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
Machine-mode interrupt controller; it is the requesting side of the pipeline interrupt handshake. It latches external interrupt edges, applies the enable masks and global MIE, and raises interrupt_req toward the hazard unit. It consumes interrupt_taken and mret_taken, and from them it updates the trap CSRs (mstatus, mie, mip, mtvec, mepc, mcause) and drives a one-cycle PC redirect into the IF stage.

Parameters:
NUM_IRQ, 8, number of external interrupt lines (1..16)
XLEN, 32, data/PC width
MTVEC_RESET, 32'h0000_0100, reset value of mtvec
VECTORED, 1, 1: handler at mtvec + 4*id; 0: all interrupts go to mtvec

Ports:
clk  in  1  core clock
rstn  in  1  synchronous active-low reset, sampled on rising clk
irq  in  NUM_IRQ  external interrupt lines, synchronous to clk, rising-edge sensitive
interrupt_req  out  1  request to the hazard unit
interrupt_taken  in  1  hazard unit accepted the request (same cycle as interrupt_req)
mret_taken  in  1  MRET retiring in WB
pc_resume  in  XLEN  PC of the oldest uncommitted instruction; captured into mepc
csr_we  in  1  CSR write strobe
csr_addr  in  12  CSR address
csr_wdata  in  XLEN  CSR write data
csr_rdata  out  XLEN  CSR read data (combinational on csr_addr)
redirect_valid  out  1  one-cycle pulse: IF must load redirect_pc
redirect_pc  out  XLEN  redirect target

Behaviour:
- Reset (rstn=0 at a clk edge): state=IDLE; pending=0; mie=0; MIE=0; MPIE=0; mtvec=MTVEC_RESET; mepc=0; mcause=0; irq_q=0; redirect_valid=0; redirect_pc=0. interrupt_req is 0 because MIE=0. Reset mid-handler returns to IDLE and clears all state.
- Edge detect: irq_q<=irq every cycle. pending[i] is set when irq[i]&!irq_q[i]. An edge sampled at edge N gives pending=1 after N and interrupt_req during cycle N+1.
- Active set: active = pending & mie[NUM_IRQ-1:0]. interrupt_req = (state==IDLE) & MIE & |active. interrupt_req is combinational from registers only and never depends on interrupt_taken.
- Priority: the lowest set index of active wins. This is id (4 bits).
- State machine:
  - IDLE: if interrupt_req & interrupt_taken, perform the following and go to HANDLER:
    - mepc<=pc_resume
    - mcause<={1'b1, (16+id) zero-extended}
    - MPIE<=MIE, MIE<=0
    - pending[id]<=0
    - redirect_pc<=VECTORED ? mtvec+4*id : mtvec; redirect_valid<=1 for 1 cycle
  - HANDLER: interrupt_req=0 (no nesting). If mret_taken: MIE<=MPIE, MPIE<=1, redirect_pc<=mepc, redirect_valid<=1 for 1 cycle; go to IDLE.
  - mret_taken in IDLE is legal. It performs the same MIE/MPIE/redirect update and stays in IDLE.
  - interrupt_taken when interrupt_req=0 is ignored.
- CSR map:
  - mstatus 0x300: bit3=MIE, bit7=MPIE; other bits read 0 and ignore writes.
  - mie 0x304: low NUM_IRQ bits.
  - mtvec 0x305: bits[1:0] forced 0.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342: full width.
  - mip 0x344: reads pending; writes are write-1-to-clear.
  - Unmapped addresses read 0 and ignore writes. A write takes effect at the next edge.
- Simultaneous events:
  - Trap entry or MRET together with a csr_we to mstatus/mepc/mcause: the trap/MRET update wins and the CSR write is dropped.
  - A new edge on irq[i] in the same cycle as a claim or W1C of bit i: the bit stays set (set wins).
  - Writing MIE=1 while pending is active raises interrupt_req the next cycle.
- Widths: redirect arithmetic is modulo 2^XLEN. 4*id is zero-extended to XLEN.

Decomposition:
- Package intr_pkg holds:
  - CSR address localparams (CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_MIP)
  - MSTATUS_MIE_BIT=3, MSTATUS_MPIE_BIT=7, MCAUSE_EXT_BASE=16
  - state enum {IDLE, HANDLER}
- One sub-module, intr_prio_enc: a NUM_IRQ-wide lowest-index priority encoder with outputs id and any.

Test Plan:
- Reset, write mie=0x01, mstatus=0x08, then pulse irq[0]: interrupt_req appears 1 cycle after the edge. With interrupt_taken=1 and pc_resume=0x200: mepc=0x200, mcause=0x8000_0010, redirect_pc=0x100, redirect_valid one cycle, MIE=0, MPIE=1.
- From HANDLER, assert mret_taken: redirect_pc=0x200, MIE=1, MPIE=1, state=IDLE, redirect pulse lasts exactly 1 cycle.
- With mie=0xFF, raise irq[5] and irq[2] in the same cycle and take the request: mcause=0x8000_0012, redirect_pc=0x108, pending=0x20 afterwards.
- In HANDLER, pulse irq[1]: interrupt_req stays 0 until mret. After mret, interrupt_req=1 the next cycle with id 1.
- Write mip=0x04 while pending=0x0C: pending=0x08. Write mip in the same cycle as a new irq[2] edge: bit 2 stays set.
- Drive rstn=0 during HANDLER: next cycle all outputs are at reset values, and mtvec=0x100 on readback.
